// File: rtl/chess_clock_pkg.sv
// Shared encodings for the chess clock core.
// State codes, preset lookup and mode word layout.
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_A  = 3'd1,
    ST_RUN_B  = 3'd2,
    ST_PAUSED = 3'd3,
    ST_FLAG   = 3'd4
  } state_t;

  localparam int MODE_STATE_LSB  = 0;
  localparam int MODE_ACTIVE     = 3;
  localparam int MODE_FLAG_A     = 4;
  localparam int MODE_FLAG_B     = 5;
  localparam int MODE_PRESET_LSB = 6;
  localparam int MODE_INC        = 8;
  localparam int MODE_MOVES_LSB  = 16;

  localparam logic [31:0] TIME_RST = 32'h003C_003C;

  function automatic logic [15:0] preset_secs(
    input logic [1:0] sel
  );
    logic [15:0] s;
    unique case (sel)
      2'b00:   s = 16'd60;
      2'b01:   s = 16'd180;
      2'b10:   s = 16'd300;
      default: s = 16'd600;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/chess_clock_if.sv
// PIO export bundle read by the HPS.
// Both words always move together.
interface chess_clock_if;
  import chess_clock_pkg::*;

  logic [31:0] time_export;
  logic [31:0] mode_export;

  modport master (
    output time_export,
    output mode_export
  );

  modport slave (
    input time_export,
    input mode_export
  );

endinterface

// File: rtl/input_sync_edge.sv
// Two-flop synchroniser plus registered rise detector.
// One single-cycle pulse per press.
module input_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/chess_clock_core.sv
// Two-player chess clock with Fischer increment.
// Exports registered time/mode snapshots to the HPS PIOs.
module chess_clock_core
  import chess_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int INC_SECONDS   = 2,
  parameter int MOVE_W        = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_start,
  input  logic       btn_game_rst,
  input  logic [1:0] preset_sel,
  input  logic       inc_en,
  chess_clock_if.master pio
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_LAST =
    PW'(TICKS_PER_SEC - 1);
  localparam logic [15:0] INC16 = 16'(INC_SECONDS);

  logic ev_a;
  logic ev_b;
  logic ev_start;
  logic ev_grst;

  input_sync_edge u_sync_a (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .d     (btn_a),
    .pulse (ev_a)
  );

  input_sync_edge u_sync_b (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .d     (btn_b),
    .pulse (ev_b)
  );

  input_sync_edge u_sync_start (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .d     (btn_start),
    .pulse (ev_start)
  );

  input_sync_edge u_sync_grst (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .d     (btn_game_rst),
    .pulse (ev_grst)
  );

  state_t            state, state_n;
  logic              active, active_n;
  logic [15:0]       ta, ta_n;
  logic [15:0]       tb, tb_n;
  logic [PW-1:0]     presc, presc_n;
  logic              fa, fa_n;
  logic              fb, fb_n;
  logic [MOVE_W-1:0] moves, moves_n;
  logic [1:0]        lat_pre, lat_pre_n;
  logic              lat_inc, lat_inc_n;

  logic        tick;
  logic        own;
  logic [15:0] cur_t;
  logic [15:0] new_t;
  logic [15:0] pre_t;
  logic [31:0] mode_n;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= ST_IDLE;
      active  <= 1'b0;
      ta      <= 16'd60;
      tb      <= 16'd60;
      presc   <= '0;
      fa      <= 1'b0;
      fb      <= 1'b0;
      moves   <= '0;
      lat_pre <= 2'b00;
      lat_inc <= 1'b0;
    end else begin
      state   <= state_n;
      active  <= active_n;
      ta      <= ta_n;
      tb      <= tb_n;
      presc   <= presc_n;
      fa      <= fa_n;
      fb      <= fb_n;
      moves   <= moves_n;
      lat_pre <= lat_pre_n;
      lat_inc <= lat_inc_n;
    end
  end

  // Priority: game reset, start/pause, tick, player key.
  always_comb begin
    state_n   = state;
    active_n  = active;
    ta_n      = ta;
    tb_n      = tb;
    presc_n   = presc;
    fa_n      = fa;
    fb_n      = fb;
    moves_n   = moves;
    lat_pre_n = lat_pre;
    lat_inc_n = lat_inc;
    tick      = (presc == TICK_LAST);
    own       = active ? ev_b : ev_a;
    cur_t     = active ? tb : ta;
    new_t     = cur_t;
    pre_t     = preset_secs(preset_sel);

    if (ev_grst) begin
      state_n   = ST_IDLE;
      active_n  = 1'b0;
      fa_n      = 1'b0;
      fb_n      = 1'b0;
      moves_n   = '0;
      presc_n   = '0;
      ta_n      = pre_t;
      tb_n      = pre_t;
      lat_pre_n = preset_sel;
      lat_inc_n = inc_en;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ta_n      = pre_t;
          tb_n      = pre_t;
          lat_pre_n = preset_sel;
          lat_inc_n = inc_en;
          if (ev_start) begin
            state_n  = ST_RUN_A;
            active_n = 1'b0;
            presc_n  = '0;
          end
        end
        ST_RUN_A, ST_RUN_B: begin
          if (ev_start) begin
            state_n = ST_PAUSED;
          end else begin
            presc_n = tick ? '0 : presc + PW'(1);
            if (tick) new_t = cur_t - 16'd1;
            if (tick && new_t == 16'd0) begin
              state_n = ST_FLAG;
              if (active) fb_n = 1'b1;
              else        fa_n = 1'b1;
            end else if (own) begin
              if (lat_inc) new_t = sat_add(new_t, INC16);
              active_n = ~active;
              state_n  = active ? ST_RUN_A : ST_RUN_B;
              presc_n  = '0;
              if (active && moves != '1)
                moves_n = moves + MOVE_W'(1);
            end
            if (active) tb_n = new_t;
            else        ta_n = new_t;
          end
        end
        ST_PAUSED: begin
          if (ev_start)
            state_n = active ? ST_RUN_B : ST_RUN_A;
        end
        ST_FLAG: begin
          state_n = ST_FLAG;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mode_n = '0;
    mode_n[MODE_STATE_LSB +: 3]  = state;
    mode_n[MODE_ACTIVE]          = active;
    mode_n[MODE_FLAG_A]          = fa;
    mode_n[MODE_FLAG_B]          = fb;
    mode_n[MODE_PRESET_LSB +: 2] = lat_pre;
    mode_n[MODE_INC]             = lat_inc;
    mode_n[MODE_MOVES_LSB +: 8]  = 8'(moves);
  end

  // Both words load on the same edge so the HPS never sees a torn pair.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pio.time_export <= TIME_RST;
      pio.mode_export <= '0;
    end else begin
      pio.time_export <= {tb, ta};
      pio.mode_export <= mode_n;
    end
  end

endmodule

// File: tb/tb_chess_clock_core.sv
// Scoreboard bench for chess_clock_core.
// Per-cycle reference model feeds an expectation queue.
module tb_chess_clock_core;

  localparam int TPS = 10;
  localparam int INC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_a;
  logic       btn_b;
  logic       btn_start;
  logic       btn_grst;
  logic [1:0] preset_sel;
  logic       inc_en;

  chess_clock_if pio ();

  chess_clock_core #(
    .TICKS_PER_SEC (TPS),
    .INC_SECONDS   (INC),
    .MOVE_W        (8)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .btn_a        (btn_a),
    .btn_b        (btn_b),
    .btn_start    (btn_start),
    .btn_game_rst (btn_grst),
    .preset_sel   (preset_sel),
    .inc_en       (inc_en),
    .pio          (pio)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: states 0 idle,1 run A,2 run B,3 paused,4 flag
  int PRESETS [4] = '{60, 180, 300, 600};
  int m_state, m_active, m_presc, m_moves, m_preset;
  int m_t [2];
  bit m_flag [2];
  bit m_inc;
  bit [3:0] hist [4];
  logic [63:0] q [$];

  function automatic logic [31:0] m_time();
    return 32'((m_t[1] << 16) | m_t[0]);
  endfunction

  function automatic logic [31:0] m_mode();
    return 32'(m_state | (m_active << 3) |
               (int'(m_flag[0]) << 4) |
               (int'(m_flag[1]) << 5) |
               (m_preset << 6) | (int'(m_inc) << 8) |
               (m_moves << 16));
  endfunction

  task automatic m_reset();
    m_state = 0; m_active = 0; m_presc = 0;
    m_moves = 0; m_preset = 0; m_inc = 0;
    m_t[0] = 60; m_t[1] = 60;
    m_flag[0] = 0; m_flag[1] = 0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
  endtask

  task automatic m_load();
    m_preset = int'(preset_sel);
    m_inc    = inc_en;
    m_t[0]   = PRESETS[m_preset];
    m_t[1]   = PRESETS[m_preset];
  endtask

  task automatic m_step();
    bit ev [4];
    bit raw [4];
    int p, t;
    bit tick;
    raw[0] = btn_a; raw[1] = btn_b;
    raw[2] = btn_start; raw[3] = btn_grst;
    for (int i = 0; i < 4; i++) begin
      ev[i]   = hist[i][2] & ~hist[i][3];
      hist[i] = {hist[i][2:0], raw[i]};
    end
    p = m_active;
    if (ev[3]) begin
      m_state = 0; m_active = 0; m_presc = 0; m_moves = 0;
      m_flag[0] = 0; m_flag[1] = 0;
      m_load();
    end else if (m_state == 0) begin
      m_load();
      if (ev[2]) begin
        m_state = 1; m_active = 0; m_presc = 0;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (ev[2]) m_state = 3;
      else begin
        tick = (m_presc == TPS - 1);
        m_presc = tick ? 0 : m_presc + 1;
        t = m_t[p] - (tick ? 1 : 0);
        if (tick && t == 0) begin
          m_flag[p] = 1;
          m_state = 4;
        end else if (ev[p]) begin
          if (m_inc) t = (t + INC > 65535) ? 65535 : t + INC;
          if (p == 1 && m_moves < 255) m_moves++;
          m_active = 1 - p;
          m_state = 1 + m_active;
          m_presc = 0;
        end
        m_t[p] = t;
      end
    end else if (m_state == 3) begin
      if (ev[2]) m_state = 1 + m_active;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
      q.push_back({32'h003C003C, 32'h0});
    end else begin
      q.push_back({m_time(), m_mode()});
      m_step();
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_time", pio.time_export, e[63:32]);
      chk("sb_mode", pio.mode_export, e[31:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which, input int hold);
    case (which)
      0: btn_a = 1;
      1: btn_b = 1;
      2: btn_start = 1;
      default: btn_grst = 1;
    endcase
    cyc(hold);
    btn_a = 0; btn_b = 0; btn_start = 0; btn_grst = 0;
  endtask

  initial begin
    bit found;
    rst = 1; btn_a = 0; btn_b = 0; btn_start = 0;
    btn_grst = 0; preset_sel = 2'b10; inc_en = 0;
    cyc(3);
    chk("rst_time", pio.time_export, 32'h003C003C);
    chk("rst_mode", pio.mode_export, 32'h0);
    rst = 0;
    cyc(3);
    chk("preset300", pio.time_export, 32'h012C012C);
    chk("preset_bits", 32'(pio.mode_export[7:6]), 32'd2);

    preset_sel = 2'b00;
    cyc(2);
    pulse(2, 2);
    cyc(15);
    pulse(3, 2);
    cyc(8);

    inc_en = 1;
    cyc(2);
    pulse(2, 2);
    cyc(12);
    pulse(0, 2);
    cyc(8);
    pulse(2, 2);
    cyc(50);
    pulse(2, 2);
    cyc(20);
    pulse(1, 2);
    cyc(8);
    chk("moves1", 32'(pio.mode_export[23:16]), 32'd1);

    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (m_state == 1 && m_t[0] == 1 && m_presc == TPS - 4)
        found = 1;
    end
    if (!found) begin
      errors++;
      $display("FAIL flag_setup timeout");
    end else begin
      pulse(0, 2);
      cyc(6);
      chk("flag_state", 32'(pio.mode_export[5:0]), 32'h14);
      chk("flag_a_time", 32'(pio.time_export[15:0]), 32'd0);
      pulse(1, 2);
      cyc(6);
      pulse(3, 2);
      cyc(6);
      chk("grst_mode", 32'(pio.mode_export[5:0]), 32'h0);
      chk("grst_time", pio.time_export, 32'h003C003C);
    end

    pulse(2, 2);
    cyc(20);
    @(posedge clk);
    #2;
    rst = 1;
    q.delete();
    #1;
    chk("async_time", pio.time_export, 32'h003C003C);
    chk("async_mode", pio.mode_export, 32'h0);
    @(negedge clk);
    btn_start = 1;
    cyc(3);
    rst = 0;
    cyc(12);
    btn_start = 0;
    cyc(6);
    chk("held_start", 32'(pio.mode_export[2:0]), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      btn_a     = btn_a ? 1'($urandom_range(0, 1))
                        : ($urandom_range(0, 99) < 4);
      btn_b     = btn_b ? 1'($urandom_range(0, 1))
                        : ($urandom_range(0, 99) < 4);
      btn_start = btn_start ? 1'($urandom_range(0, 1))
                            : ($urandom_range(0, 199) < 2);
      btn_grst  = btn_grst ? 1'($urandom_range(0, 1))
                           : ($urandom_range(0, 999) < 2);
      if ($urandom_range(0, 49) == 0)
        preset_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)
        inc_en = 1'($urandom_range(0, 1));
    end
    btn_a = 0; btn_b = 0; btn_start = 0; btn_grst = 0;
    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_clock_core.md
Name: chess_clock_core

Overview:
- FPGA-fabric producer for the two 32-bit PIO inputs that the HPS reads: time word and mode word.
- Implements a two-player chess clock with Fischer increment and a 1 Hz countdown from a parameterised prescaler.
- Publishes both words as registered, mutually consistent snapshots so the HPS never reads a torn pair.
- Sits in the top level between the board keys/switches and the soc_system PIO export ports.

Parameters:
- TICKS_PER_SEC, 50000000, clk_clk cycles per countdown second (benches use 10).
- INC_SECONDS, 2, Fischer increment added to the mover when inc_en is latched 1.
- MOVE_W, 8, move-counter width (saturating).

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset  in  1  asynchronous, active-high reset.
- btn_a  in  1  raw, asynchronous player-A "move done" key, active-high.
- btn_b  in  1  raw, asynchronous player-B "move done" key, active-high.
- btn_start  in  1  raw start/pause toggle, active-high.
- btn_game_rst  in  1  raw game reset, active-high.
- preset_sel  in  2  00=60 s, 01=180 s, 10=300 s, 11=600 s; sampled in IDLE only.
- inc_en  in  1  increment enable; sampled in IDLE only.
- time_export  out  32  [31:16] B seconds remaining, [15:0] A seconds remaining.
- mode_export  out  32  [2:0] state, [3] active player (0=A), [4] flag_a, [5] flag_b, [7:6] latched preset, [8] latched inc_en, [15:9] 0, [23:16] move count, [31:24] 0.

Behaviour:
- Every raw button passes through a 2-FF synchroniser and a rising-edge detector; each press yields one 1-cycle event. Internal state updates on the 3rd clk_clk edge after the first edge that samples the button high. Exports update one edge after that.
- States: IDLE=0, RUN_A=1, RUN_B=2, PAUSED=3, FLAG=4.
- Reset values:
  - state IDLE; A and B times = 60; prescaler 0; move count 0; flags 0; active player A; latched preset 00; latched inc_en 0.
  - time_export = 0x003C003C; mode_export = 0x00000000.
- IDLE:
  - Every cycle, reload both times from preset_sel and latch preset_sel and inc_en.
  - Start event goes to RUN_A with the prescaler cleared.
- RUN_x:
  - The prescaler counts 0..TICKS_PER_SEC-1. On wrap, a tick decrements the active player's time.
  - If a tick takes the time from 1 to 0: go to FLAG and set flag_x.
  - Own-button event: add INC_SECONDS to the mover if inc enabled (saturate at 0xFFFF), switch to the other RUN state, clear the prescaler. Move count +1 (saturating) when B completes a move.
  - The non-active player's button is ignored.
  - Start event goes to PAUSED; the prescaler holds and the active player is remembered.
- PAUSED: a start event returns to the remembered RUN state with the prescaler value retained. Player buttons are ignored.
- FLAG: times frozen. Only a game-reset event leaves FLAG, going to IDLE.
- Priority within one cycle: game reset > start/pause > tick > player button.
  - Tick plus own button in the same cycle: the decrement applies first. If it flags, FLAG wins and the press is discarded. Otherwise the increment is added to the decremented value.
  - Both player buttons in the same cycle: only the active player's button counts.
- Game reset from any state goes to IDLE, clears flags, move count and prescaler, and reloads presets the same cycle.
- Asynchronous reset asserted mid-game forces all reset values immediately, including the synchroniser flops.
- time_export and mode_export load from the same registers on the same edge; neither changes in any other cycle.

Decomposition:
- Package chess_clock_pkg holds:
  - state encoding constants;
  - the preset-seconds lookup (4 entries);
  - mode_export bit-position constants.
- Sub-module input_sync_edge: 2-FF synchroniser plus rise detector, asynchronously reset to 0. Instantiated 4 times.
- Everything else (FSM, prescaler, time arithmetic, export registers) lives in chess_clock_core.

Test Plan:
- Reset release, TICKS_PER_SEC=10 -> time_export=0x003C003C, mode_export=0; with preset_sel=10 the next cycles give time_export=0x012C012C and mode_export[7:6]=10.
- Preset 00, inc_en=0, start, wait 10 cycles after entry -> A=59 (0x003C003B), B unchanged, mode_export[2:0]=1.
- inc_en=1, A at 59, btn_a pulse -> A=61, state RUN_B, bit3=1, prescaler restart; then btn_b -> move count 1 (mode_export[23:16]=0x01).
- RUN_B, start pulse, hold 50 cycles -> time_export unchanged, state 3; start again -> resumes RUN_B and the next tick occurs after the remaining prescaler count.
- A at 1 s, btn_a edge in the same cycle as the final tick -> A=0, state FLAG, flag_a=1, no increment; further btn_b ignored; btn_game_rst -> IDLE, flags cleared.
- Assert reset_reset mid-RUN_A between clock edges -> outputs return to reset values asynchronously; a held btn_start after release produces exactly one start event.
